// File: rtl/hdmi_audio_pkg.sv
// rtl/hdmi_audio_pkg.sv - shared defaults, types and I2S slot constants for HDMI audio sources
package hdmi_audio_pkg;

  localparam int AUDIO_DATA_W     = 16;
  localparam int AUDIO_CLK_DIV    = 4;
  localparam int AUDIO_FIFO_DEPTH = 4;
  localparam int I2S_CHANNELS     = 2;

  typedef enum logic {
    WS_LEFT  = 1'b0,
    WS_RIGHT = 1'b1
  } i2s_ws_e;

  function automatic int i2s_frame_slots(input int data_w);
    return I2S_CHANNELS * data_w;
  endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// rtl/audio_sample_fifo.sv - synchronous sample-pair FIFO with occupancy count
module audio_sample_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/i2s_audio_tx.sv
// rtl/i2s_audio_tx.sv - stereo I2S serializer fed from a sample-pair FIFO
module i2s_audio_tx
  import hdmi_audio_pkg::*;
#(
  parameter int DATA_W     = AUDIO_DATA_W,
  parameter int CLK_DIV    = AUDIO_CLK_DIV,
  parameter int FIFO_DEPTH = AUDIO_FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        en,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_left,
  input  logic [DATA_W-1:0]           in_right,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        underrun,
  input  logic                        clr_underrun,
  output logic                        sclk,
  output logic                        lrclk,
  output logic                        sd
);

  localparam int SLOTS = i2s_frame_slots(DATA_W);
  localparam int BW    = $clog2(SLOTS);
  localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] SLOT_LAST  = BW'(SLOTS - 1);
  localparam logic [BW-1:0] SLOT_RIGHT = BW'(DATA_W);

  logic [DW-1:0]    r_div_cnt;
  logic             r_sclk;
  logic [BW-1:0]    r_bit_cnt;
  i2s_ws_e          r_ws;
  logic             r_sd;
  logic [SLOTS-1:0] r_frame;
  logic             r_underrun;

  logic             w_fall;
  logic             w_frame_start;
  logic [BW-1:0]    w_bit_nxt;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [SLOTS-1:0] w_fifo_rdata;

  audio_sample_fifo #(
    .WIDTH (SLOTS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (in_valid),
    .i_wdata ({in_left, in_right}),
    .i_pop   (w_frame_start),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (level)
  );

  assign w_fall        = en && r_sclk && (r_div_cnt == DIV_LAST);
  assign w_bit_nxt     = (r_bit_cnt == SLOT_LAST) ? '0 : r_bit_cnt + 1'b1;
  assign w_frame_start = w_fall && (w_bit_nxt == '0);

  // The frame register shifts MSB-first; emitting its MSB before the shift gives
  // the one-slot I2S delay, so slot 0 still carries the old frame's R[LSB].
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div_cnt <= '0;
      r_sclk    <= 1'b0;
      r_bit_cnt <= SLOT_LAST;
      r_ws      <= WS_LEFT;
      r_sd      <= 1'b0;
      r_frame   <= '0;
    end else if (!en) begin
      r_div_cnt <= '0;
      r_sclk    <= 1'b0;
      r_bit_cnt <= SLOT_LAST;
      r_ws      <= WS_LEFT;
      r_sd      <= 1'b0;
      r_frame   <= '0;
    end else begin
      if (r_div_cnt == DIV_LAST) begin
        r_div_cnt <= '0;
        r_sclk    <= !r_sclk;
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end
      if (w_fall) begin
        r_bit_cnt <= w_bit_nxt;
        r_ws      <= (w_bit_nxt >= SLOT_RIGHT) ? WS_RIGHT : WS_LEFT;
        r_sd      <= r_frame[SLOTS-1];
        if (w_frame_start) r_frame <= w_fifo_empty ? '0 : w_fifo_rdata;
        else               r_frame <= {r_frame[SLOTS-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          r_underrun <= 1'b0;
    else if (w_frame_start && w_fifo_empty) r_underrun <= 1'b1;
    else if (clr_underrun)                 r_underrun <= 1'b0;
  end

  assign in_ready = !w_fifo_full;
  assign underrun = r_underrun;
  assign sclk     = r_sclk;
  assign lrclk    = r_ws;
  assign sd       = r_sd;

endmodule

// File: tb/tb_i2s_audio_tx.sv
// tb/tb_i2s_audio_tx.sv - vector-table and scoreboard bench for i2s_audio_tx
`timescale 1ns/1ps
module tb_i2s_audio_tx;

  localparam int DATA_W     = 16;
  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int FS_FIRST   = 2 * CLK_DIV;
  localparam int SLOT_CYC   = 2 * CLK_DIV;
  localparam int FRAME_CYC  = 4 * CLK_DIV * DATA_W;
  localparam int FW         = 2 * DATA_W;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic en = 1'b0;
  logic in_valid = 1'b0;
  logic clr_underrun = 1'b0;
  logic [DATA_W-1:0] in_left = '0;
  logic [DATA_W-1:0] in_right = '0;
  logic in_ready, underrun, sclk, lrclk, sd;
  logic [$clog2(FIFO_DEPTH):0] level;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  i2s_audio_tx #(
    .DATA_W     (DATA_W),
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .en           (en),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_left      (in_left),
    .in_right     (in_right),
    .level        (level),
    .underrun     (underrun),
    .clr_underrun (clr_underrun),
    .sclk         (sclk),
    .lrclk        (lrclk),
    .sd           (sd)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: FIFO contents, expected frame sequence and sticky flag.
  logic [FW-1:0] m_fifo[$];
  logic [FW-1:0] exp_q[$];
  bit m_underrun, m_en_seen, m_push, m_fs, m_set;
  int en_cyc;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_fifo.delete();
      exp_q.delete();
      m_underrun = 1'b0;
      m_en_seen  = 1'b0;
      en_cyc     = 0;
    end else begin
      m_push    = in_valid && (m_fifo.size() < FIFO_DEPTH);
      m_fs      = 1'b0;
      m_set     = 1'b0;
      m_en_seen = en;
      if (en) begin
        en_cyc++;
        m_fs = (en_cyc >= FS_FIRST) && (((en_cyc - FS_FIRST) % FRAME_CYC) == 0);
      end else begin
        en_cyc = 0;
        exp_q.delete();
      end
      if (m_fs) begin
        if (m_fifo.size() > 0) exp_q.push_back(m_fifo.pop_front());
        else begin
          exp_q.push_back('0);
          m_set = 1'b1;
        end
      end
      if (m_push) m_fifo.push_back({in_left, in_right});
      if (m_set) m_underrun = 1'b1;
      else if (clr_underrun) m_underrun = 1'b0;
    end
  end

  // Receiver: sample sd on sclk rise; a right-to-left word-select change closes a frame.
  logic prev_sclk, prev_lr;
  logic [FW-1:0] sr;
  int frames_done = 0;
  bit cyc_chk_en = 1'b0;

  always @(negedge clk) begin
    if (!reset_n || !m_en_seen) begin
      prev_sclk = 1'b0;
      prev_lr   = 1'b0;
      sr        = '0;
    end else begin
      if (sclk && !prev_sclk) begin
        sr = {sr[FW-2:0], sd};
        if (!lrclk && prev_lr) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL frame_unexpected actual=%0h required=none", sr);
          end else begin
            check("frame", sr, exp_q.pop_front());
          end
          frames_done++;
        end
        prev_lr = lrclk;
      end
      prev_sclk = sclk;
    end
  end

  always @(negedge clk) begin
    if (reset_n && cyc_chk_en) begin
      check("level", level, m_fifo.size());
      check("in_ready", in_ready, m_fifo.size() < FIFO_DEPTH);
      check("underrun", underrun, m_underrun);
    end
  end

  typedef struct {
    int   slot;
    logic exp_sd;
    logic exp_lr;
  } slot_vec_t;

  typedef struct {
    logic [DATA_W-1:0] l;
    logic [DATA_W-1:0] r;
  } pair_t;

  slot_vec_t slot_tab[33];
  pair_t     pair_tab[5];

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    en = 1'b0;
    in_valid = 1'b0;
    clr_underrun = 1'b0;
    cycles(2);
    reset_n = 1'b1;
    cycles(1);
  endtask

  task automatic push_pair(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
    in_valid = 1'b1;
    in_left  = l;
    in_right = r;
    cycles(1);
    in_valid = 1'b0;
  endtask

  initial begin
    logic [FW-1:0] exp_bits;
    int n, tgt, fd0, idx;
    bit hs;

    exp_bits = 32'b1000_0000_0000_0001_0111_1111_1111_1110;
    for (int k = 0; k <= 32; k++) begin
      slot_tab[k].slot   = k;
      slot_tab[k].exp_sd = (k == 0) ? 1'b0 : exp_bits[32-k];
      slot_tab[k].exp_lr = (k >= 16) && (k <= 31);
    end
    pair_tab[0] = '{16'h1234, 16'hABCD};
    pair_tab[1] = '{16'hFFFF, 16'h0000};
    pair_tab[2] = '{16'h8000, 16'h7FFF};
    pair_tab[3] = '{16'h0001, 16'hFFFE};
    pair_tab[4] = '{16'h5A5A, 16'hA5A5};

    // Reset state
    cycles(2);
    check("rst_sclk", sclk, 0);
    check("rst_lrclk", lrclk, 0);
    check("rst_sd", sd, 0);
    check("rst_underrun", underrun, 0);
    check("rst_level", level, 0);
    check("rst_in_ready", in_ready, 1);
    reset_n = 1'b1;
    cycles(1);
    cyc_chk_en = 1'b1;

    // Single pair 8001/7FFE, slot-by-slot
    push_pair(16'h8001, 16'h7FFE);
    fd0 = frames_done;
    en = 1'b1;
    cycles(FS_FIRST - 1);
    check("t1_level_before_pop", level, 1);
    cycles(1);
    check("t1_level_at_pop", level, 0);
    n = FS_FIRST;
    for (int i = 0; i < 33; i++) begin
      tgt = FS_FIRST + SLOT_CYC * slot_tab[i].slot + 2;
      cycles(tgt - n);
      n = tgt;
      check($sformatf("t1_slot%0d_sd", slot_tab[i].slot), sd, slot_tab[i].exp_sd);
      check($sformatf("t1_slot%0d_lrclk", slot_tab[i].slot), lrclk, slot_tab[i].exp_lr);
      check($sformatf("t1_slot%0d_sclk", slot_tab[i].slot), sclk, 0);
    end
    cycles(6);
    check("t1_frames", frames_done - fd0, 1);

    // Empty FIFO: underrun, clear, then set/clear collision
    do_reset();
    fd0 = frames_done;
    en = 1'b1;
    cycles(FS_FIRST);
    check("t2_underrun_set", underrun, 1);
    cycles(2);
    clr_underrun = 1'b1;
    cycles(1);
    clr_underrun = 1'b0;
    check("t2_underrun_clr", underrun, 0);
    cycles(FS_FIRST + FRAME_CYC - 1 - (FS_FIRST + 3));
    clr_underrun = 1'b1;
    cycles(1);
    clr_underrun = 1'b0;
    check("t2_set_wins", underrun, 1);
    cycles(FRAME_CYC + 10);
    check("t2_frames", frames_done - fd0, 2);

    // Five pairs with in_valid held: back-pressure and ordering
    do_reset();
    fd0 = frames_done;
    idx = 0;
    in_valid = 1'b1;
    in_left  = pair_tab[0].l;
    in_right = pair_tab[0].r;
    for (int c = 0; c < 10 && idx < 4; c++) begin
      hs = in_ready;
      cycles(1);
      if (hs) begin
        idx++;
        in_left  = pair_tab[idx].l;
        in_right = pair_tab[idx].r;
      end
    end
    check("t3_level_full", level, 4);
    check("t3_ready_full", in_ready, 0);
    en = 1'b1;
    cycles(FS_FIRST - 1);
    check("t3_ready_before_pop", in_ready, 0);
    cycles(1);
    check("t3_ready_after_pop", in_ready, 1);
    check("t3_level_after_pop", level, 3);
    cycles(1);
    in_valid = 1'b0;
    check("t3_level_refill", level, 4);
    cycles(5 * FRAME_CYC + 10);
    check("t3_frames", frames_done - fd0, 5);

    // Push into an empty FIFO exactly on the frame-start cycle
    do_reset();
    fd0 = frames_done;
    en = 1'b1;
    cycles(FS_FIRST - 1);
    push_pair(16'hC3C3, 16'h3C3C);
    check("t4_underrun", underrun, 1);
    check("t4_level_kept", level, 1);
    cycles(FRAME_CYC);
    check("t4_level_popped", level, 0);
    cycles(FRAME_CYC + 8);
    check("t4_frames", frames_done - fd0, 2);

    // en dropped mid-frame at slot 10, push while disabled, re-enable
    do_reset();
    push_pair(16'h00FF, 16'h1111);
    push_pair(16'hABCD, 16'h1357);
    fd0 = frames_done;
    en = 1'b1;
    cycles(FS_FIRST + SLOT_CYC * 10 + 5);
    check("t5_sclk_high", sclk, 1);
    check("t5_sd_slot10", sd, 1);
    en = 1'b0;
    cycles(1);
    check("t5_off_sclk", sclk, 0);
    check("t5_off_lrclk", lrclk, 0);
    check("t5_off_sd", sd, 0);
    check("t5_off_level", level, 1);
    push_pair(16'h2468, 16'hFEDC);
    check("t5_push_while_off", level, 2);
    en = 1'b1;
    cycles(FS_FIRST - 1);
    check("t5_level_before_restart", level, 2);
    cycles(1);
    check("t5_level_restart_pop", level, 1);
    cycles(FRAME_CYC);
    check("t5_level_second_pop", level, 0);
    cycles(FRAME_CYC + 8);
    check("t5_frames", frames_done - fd0, 2);

    // Asynchronous reset mid-frame
    do_reset();
    push_pair(16'h00FF, 16'h1111);
    push_pair(16'hABCD, 16'h1357);
    en = 1'b1;
    cycles(FS_FIRST + SLOT_CYC * 20 + 5);
    check("t6_sclk_pre", sclk, 1);
    check("t6_lrclk_pre", lrclk, 1);
    check("t6_sd_pre", sd, 1);
    check("t6_level_pre", level, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_async_sclk", sclk, 0);
    check("t6_async_lrclk", lrclk, 0);
    check("t6_async_sd", sd, 0);
    check("t6_async_level", level, 0);
    check("t6_async_in_ready", in_ready, 1);
    en = 1'b0;
    cycles(1);
    reset_n = 1'b1;
    cycles(2);
    check("t6_level_after", level, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
